// File: rtl/if_id_skid_if.sv
// Fetch/decode handshake bundle for the IF/ID skid register.
// slave  : the pipeline register itself (consumes the if_* offer, drives id_*)
// master : the surrounding fetch/decode logic (or a testbench)
interface if_id_skid_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic              if_valid;
    logic              if_ready;
    logic [ADDR_W-1:0] if_pc;
    logic [INST_W-1:0] if_inst;
    logic              id_valid;
    logic              id_ready;
    logic [ADDR_W-1:0] id_pc;
    logic [INST_W-1:0] id_inst;

    modport master (
        output if_valid, if_pc, if_inst, id_ready,
        input  if_ready, id_valid, id_pc, id_inst
    );

    modport slave (
        input  if_valid, if_pc, if_inst, id_ready,
        output if_ready, id_valid, id_pc, id_inst
    );
endinterface

// File: rtl/if_id_skid.sv
// IF/ID pipeline register with a 2-entry (main + skid) buffer.
// if_ready is a pure flop output (!skid_v), id_* come straight from the main
// entry, so there is no combinational path from any input to any output.
// Optional build macro IF_ID_PERF_EN adds saturating stall/flush counters.
module if_id_skid #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = '0
) (
    input  logic         clk,
    input  logic         rst,        // asynchronous, active-low
    input  logic         flush,
    if_id_skid_if.slave  bus
`ifdef IF_ID_PERF_EN
    ,
    output logic [31:0]  stall_cnt,
    output logic [31:0]  flush_cnt
`endif
);

    logic              main_v_q, main_v_d;
    logic              skid_v_q, skid_v_d;
    logic [ADDR_W-1:0] main_pc_q, main_pc_d;
    logic [INST_W-1:0] main_inst_q, main_inst_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
    logic [INST_W-1:0] skid_inst_q, skid_inst_d;
    logic              push;
    logic              pop;

    // A full skid entry blocks new input until it has drained into main.
    assign push = bus.if_valid & ~skid_v_q;
    assign pop  = main_v_q & bus.id_ready;

    assign bus.if_ready = ~skid_v_q;
    assign bus.id_valid = main_v_q;
    assign bus.id_pc    = main_pc_q;
    assign bus.id_inst  = main_inst_q;

    // Next-state selection: flush wins, then advance, then stall/park in skid.
    always_comb begin
        main_v_d    = main_v_q;
        skid_v_d    = skid_v_q;
        main_pc_d   = main_pc_q;
        main_inst_d = main_inst_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;
        if (flush) begin
            // Any simultaneous offer is dropped; fetch is redirecting too.
            main_v_d    = 1'b0;
            skid_v_d    = 1'b0;
            main_pc_d   = '0;
            main_inst_d = NOP_INST;
        end else if (pop || !main_v_q) begin
            if (skid_v_q) begin
                // Older skid entry goes first to keep program order.
                main_v_d    = 1'b1;
                skid_v_d    = 1'b0;
                main_pc_d   = skid_pc_q;
                main_inst_d = skid_inst_q;
            end else if (push) begin
                main_v_d    = 1'b1;
                main_pc_d   = bus.if_pc;
                main_inst_d = bus.if_inst;
            end else begin
                // Bubble: present a clean NOP so decode never sees stale data.
                main_v_d    = 1'b0;
                main_pc_d   = '0;
                main_inst_d = NOP_INST;
            end
        end else if (push) begin
            // Decode stalled with main occupied: catch the in-flight offer.
            skid_v_d    = 1'b1;
            skid_pc_d   = bus.if_pc;
            skid_inst_d = bus.if_inst;
        end
    end

    // State registers; reset discards both entries immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_v_q    <= 1'b0;
            skid_v_q    <= 1'b0;
            main_pc_q   <= '0;
            main_inst_q <= NOP_INST;
            skid_pc_q   <= '0;
            skid_inst_q <= NOP_INST;
        end else begin
            main_v_q    <= main_v_d;
            skid_v_q    <= skid_v_d;
            main_pc_q   <= main_pc_d;
            main_inst_q <= main_inst_d;
            skid_pc_q   <= skid_pc_d;
            skid_inst_q <= skid_inst_d;
        end
    end

`ifdef IF_ID_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Count decode stall cycles and flushes that actually killed something.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (main_v_q && !bus.id_ready) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
            if (flush && (main_v_q || skid_v_q)) begin
                flush_cnt_q <= sat_inc(flush_cnt_q);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
